// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// The hex table is shared with the upstream per-digit decoders.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Nibble to active-low segment pattern, for upstream decoders.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = SEG_BLANK;
        case (h)
            4'h0: s = SEG_HEX_0;
            4'h1: s = SEG_HEX_1;
            4'h2: s = SEG_HEX_2;
            4'h3: s = SEG_HEX_3;
            4'h4: s = SEG_HEX_4;
            4'h5: s = SEG_HEX_5;
            4'h6: s = SEG_HEX_6;
            4'h7: s = SEG_HEX_7;
            4'h8: s = SEG_HEX_8;
            4'h9: s = SEG_HEX_9;
            4'hA: s = SEG_HEX_A;
            4'hB: s = SEG_HEX_B;
            4'hC: s = SEG_HEX_C;
            4'hD: s = SEG_HEX_D;
            4'hE: s = SEG_HEX_E;
            default: s = SEG_HEX_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Upstream-facing bundle of the scanner: load handshake, pattern data and pins.
// Latency: n/a (wiring only).
// Backpressure: none; load is always accepted, load_ack reports the frame-boundary copy.
//
// master: display-data producer / pin consumer.  slave: the scanner.
// Optional macro SSEG_SCAN_DIM_EN adds the 4-bit brightness input.
interface sseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7
);
    logic                        en;
    logic                        load;
    logic [NUM_DIGITS*SEG_W-1:0] seg_in;
    logic [NUM_DIGITS-1:0]       dp_in;
`ifdef SSEG_SCAN_DIM_EN
    logic [3:0]                  bright;
`endif
    logic                        load_ack;
    logic                        frame_tick;
    logic [NUM_DIGITS-1:0]       an;
    logic [SEG_W-1:0]            sseg;
    logic                        dp;

    modport master (
`ifdef SSEG_SCAN_DIM_EN
        output bright,
`endif
        output en, load, seg_in, dp_in,
        input  load_ack, frame_tick, an, sseg, dp
    );

    modport slave (
`ifdef SSEG_SCAN_DIM_EN
        input  bright,
`endif
        input  en, load, seg_in, dp_in,
        output load_ack, frame_tick, an, sseg, dp
    );

endinterface

// File: rtl/sseg_prescaler.sv
// Digit-slot prescaler: div_cnt counts 0..CLK_DIV-1 while enabled, slot_tick on the last count.
// Latency: slot_tick is combinational from the registered count.
// Backpressure: en=0 freezes the count and suppresses slot_tick.
//
// Ports: clk, rst (sync, active-high), en, div_cnt (current count), slot_tick.
module sseg_prescaler
    import sseg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    localparam int CNT_W  = cnt_width(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] div_cnt,
    output logic             slot_tick
);

    logic [CNT_W-1:0] r_cnt;

    assign slot_tick = en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign div_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= slot_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-synchronous double-buffered display data.
// Latency: pins lag the digit index by 1 cycle; load visible within NUM_DIGITS*CLK_DIV+1 enabled cycles.
// Backpressure: none; loads overwrite the shadow (last wins), load_ack pulses when it reaches the display.
//
// Ports: clk, rst (sync, active-high), bus (sseg_scan_ctrl_if.slave):
//   en, load, seg_in, dp_in [, bright] in; load_ack, frame_tick, an, sseg, dp out.
// Optional macro SSEG_SCAN_DIM_EN: PWM-dims the anodes within each slot by bright.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int SEG_W      = 7
) (
    input  logic           clk,
    input  logic           rst,
    sseg_scan_ctrl_if.slave bus
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam logic [SEG_W-1:0] BLANK_SEG = '1;

    logic [CNT_W-1:0]            w_div_cnt;
    logic                        w_slot_tick;
    logic                        w_boundary;
    logic                        w_an_on;
    logic [NUM_DIGITS-1:0]       w_an_sel;

    logic [IDX_W-1:0]            r_idx;
    logic                        r_pending;
    logic [NUM_DIGITS*SEG_W-1:0] r_shadow_seg;
    logic [NUM_DIGITS-1:0]       r_shadow_dp;
    logic [NUM_DIGITS*SEG_W-1:0] r_active_seg;
    logic [NUM_DIGITS-1:0]       r_active_dp;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [SEG_W-1:0]            r_sseg;
    logic                        r_dp;
    logic                        r_load_ack;
    logic                        r_frame_tick;

    sseg_prescaler #(
        .CLK_DIV   (CLK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.en),
        .div_cnt   (w_div_cnt),
        .slot_tick (w_slot_tick)
    );

    // Last slot of the frame ending; with one digit every slot is a boundary.
    assign w_boundary = w_slot_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_an_sel   = NUM_DIGITS'(1) << r_idx;

`ifdef SSEG_SCAN_DIM_EN
    // Anode on while div_cnt*16 < (bright+1)*CLK_DIV; PW bits hold both sides
    // without truncation since CLK_DIV <= 2**CNT_W.
    localparam int PW = CNT_W + 5;
    logic [4:0]    w_bright_p1;
    logic [PW-1:0] w_dim_lhs;
    logic [PW-1:0] w_dim_rhs;

    assign w_bright_p1 = {1'b0, bus.bright} + 5'd1;
    assign w_dim_lhs   = PW'({w_div_cnt, 4'b0000});
    assign w_dim_rhs   = PW'(w_bright_p1) * PW'(CLK_DIV);
    assign w_an_on     = (w_dim_lhs < w_dim_rhs);
`else
    assign w_an_on     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_shadow_seg <= '1;
            r_shadow_dp  <= '0;
            r_active_seg <= '1;
            r_active_dp  <= '0;
            r_an         <= '1;
            r_sseg       <= BLANK_SEG;
            r_dp         <= DP_OFF;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_tick) begin
                r_idx <= w_boundary ? '0 : r_idx + 1'b1;
            end

            if (bus.load) begin
                r_shadow_seg <= bus.seg_in;
                r_shadow_dp  <= bus.dp_in;
            end

            // Copies the shadow as it stood before this cycle, so a load landing
            // on the boundary stays pending for the following frame.
            if (w_boundary && r_pending) begin
                r_active_seg <= r_shadow_seg;
                r_active_dp  <= r_shadow_dp;
            end

            r_pending    <= bus.load | (r_pending & ~w_boundary);
            r_load_ack   <= w_boundary & r_pending;
            r_frame_tick <= w_boundary;

            if (bus.en) begin
                r_an   <= w_an_on ? ~w_an_sel : '1;
                r_sseg <= r_active_seg[r_idx*SEG_W +: SEG_W];
                r_dp   <= ~r_active_dp[r_idx];
            end else begin
                r_an   <= '1;
                r_sseg <= BLANK_SEG;
                r_dp   <= DP_OFF;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.sseg       = r_sseg;
    assign bus.dp         = r_dp;
    assign bus.load_ack   = r_load_ack;
    assign bus.frame_tick = r_frame_tick;

endmodule
